// File: rtl/reg_dump_streamer_pkg.sv
// Shared definitions for the register-dump readout path.
// The register address width is also used by the register file and the
// compute sequencer, so it lives here rather than in the streamer.
package reg_dump_streamer_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int REG_ADDR_W   = 5;

  // Dump sequencer states; CKSUM/CSEND are only reachable with the checksum built in.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_SEND,
    S_CKSUM,
    S_CSEND,
    S_DONE
  } dump_state_e;

  // Address of the final register in a dump of num_regs registers.
  function automatic logic [REG_ADDR_W-1:0] last_addr(input int num_regs);
    return REG_ADDR_W'(num_regs - 1);
  endfunction

endpackage

// File: rtl/reg_dump_streamer_checksum.sv
// dump_checksum: clear/accumulate adder register for the trailing checksum word.
// Sum wraps modulo 2^DATA_W. Only instantiated when REG_DUMP_CHECKSUM_EN is defined.
module dump_checksum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              acc,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  // Clear wins over accumulate so a fresh dump never inherits a stale sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sum <= '0;
    else if (clr) sum <= '0;
    else if (acc) sum <= sum + din;
  end

endmodule

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: walks register addresses 0..NUM_REGS-1 through a spare
// register-file read port and emits one word per register on a valid/ready stream.
// Optional feature: define REG_DUMP_CHECKSUM_EN to append a wrap-around sum word
// that carries out_last; otherwise out_last rides on the final register word.
module reg_dump_streamer
  import reg_dump_streamer_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [REG_ADDR_W-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] LAST_ADDR = last_addr(NUM_REGS);

  dump_state_e state;
  logic        hs;

  assign hs = out_valid & out_ready;

`ifdef REG_DUMP_CHECKSUM_EN
  // Register words never carry last; the checksum word closes the dump.
  localparam logic LAST_ON_REG = 1'b0;

  logic [DATA_W-1:0] sum;

  // Sum restarts on start acceptance and picks up each word as it is loaded.
  dump_checksum #(
    .DATA_W (DATA_W)
  ) u_cksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == S_IDLE && start),
    .acc   (state == S_LOAD),
    .din   (rd_data),
    .sum   (sum)
  );
`else
  localparam logic LAST_ON_REG = 1'b1;
`endif

  // Dump sequencer; all stream outputs are registered here and held until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= S_WAIT;
          end
        end
        // One settle cycle so rd_data reflects the freshly registered rd_addr.
        S_WAIT: state <= S_LOAD;
        S_LOAD: begin
          out_data  <= rd_data;
          out_addr  <= rd_addr;
          out_valid <= 1'b1;
          out_last  <= LAST_ON_REG && (rd_addr == LAST_ADDR);
          state     <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (rd_addr == LAST_ADDR) begin
`ifdef REG_DUMP_CHECKSUM_EN
              state <= S_CKSUM;
`else
              // done/busy change on the final handshake so done is seen the next cycle.
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
`endif
            end else begin
              rd_addr <= rd_addr + 1'b1;
              state   <= S_WAIT;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        S_CKSUM: begin
          out_data  <= sum;
          out_addr  <= '0;
          out_last  <= 1'b1;
          out_valid <= 1'b1;
          state     <= S_CSEND;
        end
        S_CSEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end
        end
`endif
        // Start seen here is dropped: the sequencer only listens in IDLE.
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Bench for reg_dump_streamer: scenario table plus a reset-abort sequence.
// Expected stream words are queued when a dump is launched and popped on handshakes.
module tb_reg_dump_streamer;
  import reg_dump_streamer_pkg::*;

  localparam int NR = 32;
  localparam int DW = 32;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CK   = 1'b1;
  localparam int BASE = 98;
`else
  localparam bit CK   = 1'b0;
  localparam int BASE = 96;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [4:0]    rd_addr, out_addr;
  logic [DW-1:0] rd_data, out_data;
  logic          out_valid, out_last, busy, done;
  logic [DW-1:0] rf [NR];

  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  reg_dump_streamer #(.NUM_REGS(NR), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [4:0]    addr;
    logic          last;
  } word_t;

  typedef struct {
    int            mode;      // 0 fib, 1 all ones, 2 random
    int            bp_word;   // register index to stall on, -1 none
    int            bp_len;    // stall cycles
    bit            rep;       // fire extra start pulses mid-dump and in DONE
    logic [DW-1:0] exp_sum;   // checksum for fixed patterns
    int            exp_done;  // edges from start to the cycle done is high
  } scn_t;

  word_t q[$];
  scn_t  tbl[5];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < NR; i++) begin
      case (mode)
        0:       rf[i] = (i < 2) ? 32'd1 : rf[i-1] + rf[i-2];
        1:       rf[i] = 32'hFFFF_FFFF;
        default: rf[i] = $urandom;
      endcase
    end
  endtask

  task automatic run_dump(input scn_t s);
    word_t         w, e;
    logic [DW-1:0] msum;
    logic [DW-1:0] snap_d;
    logic [4:0]    snap_a;
    bit            held;
    int            bp_left, done_n, dones, n;

    msum = '0;
    q.delete();
    for (int i = 0; i < NR; i++) begin
      w.data = rf[i];
      w.addr = 5'(i);
      w.last = !CK && (i == NR - 1);
      q.push_back(w);
      msum = msum + rf[i];
    end
    if (CK) begin
      w.data = (s.mode == 2) ? msum : s.exp_sum;
      w.addr = '0;
      w.last = 1'b1;
      q.push_back(w);
    end

    bp_left = s.bp_len;
    done_n  = -1;
    dones   = 0;
    held    = 1'b0;
    snap_d  = '0;
    snap_a  = '0;

    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    while (n < 400 && !(done_n >= 0 && n >= done_n + 6)) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) chk("valid_low_k1", 32'(out_valid), 32'd0);
      if (n == 2) begin
        chk("first_valid_k2", 32'(out_valid), 32'd1);
        chk("first_addr", 32'(out_addr), 32'd0);
      end
      out_ready = 1'b1;
      if (out_valid && int'(out_addr) == s.bp_word && bp_left > 0 && !(CK && out_last)) begin
        out_ready = 1'b0;
        bp_left--;
      end
      if (out_valid && !out_ready) begin
        if (held) begin
          chk("stall_data", out_data, snap_d);
          chk("stall_addr", 32'(out_addr), 32'(snap_a));
        end
        chk("stall_rd_addr", 32'(rd_addr), 32'(out_addr));
        snap_d = out_data;
        snap_a = out_addr;
        held   = 1'b1;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_word", 32'(out_addr), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("word_data", out_data, e.data);
          chk("word_addr", 32'(out_addr), 32'(e.addr));
          chk("word_last", 32'(out_last), 32'(e.last));
          if (s.mode == 0 && !out_last && out_addr == 5'd31)
            chk("fib_r31", out_data, 32'd2178309);
        end
        if (s.rep && (out_addr == 5'd3 || out_addr == 5'd20) && !(CK && out_last))
          start = 1'b1;
      end
      if (done) begin
        dones++;
        if (done_n < 0) done_n = n;
        if (s.rep) start = 1'b1;
      end
      @(posedge clk);
      #1 n++;
    end
    start = 1'b0;
    chk("done_cycle", 32'(done_n), 32'(s.exp_done));
    chk("done_pulses", 32'(dones), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("valid_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int guard;

    tbl[0] = '{0, -1, 0, 1'b0, 32'h0057_04E6, BASE};
    tbl[1] = '{0,  7, 5, 1'b0, 32'h0057_04E6, BASE + 5};
    tbl[2] = '{0, -1, 0, 1'b1, 32'h0057_04E6, BASE};
    tbl[3] = '{1, -1, 0, 1'b0, 32'hFFFF_FFE0, BASE};
    tbl[4] = '{2, 31, 2, 1'b0, 32'h0000_0000, BASE + 2};

    fill(0);
    #2;
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      fill(tbl[t].mode);
      run_dump(tbl[t]);
    end

    // Abort a dump while word 10 is on the stream, then restart from scratch.
    fill(0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (!(out_valid && out_addr == 5'd10) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_word10", 32'(out_addr), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd_addr", 32'(rd_addr), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_data", out_data, 32'd0);
    chk("abort_addr", 32'(out_addr), 32'd0);
    chk("abort_last", 32'(out_last), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_dump(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
